// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types for the two-client (I-cache / D-cache) memory arbiter.
//   arb_state_e  : arbiter FSM states (IDLE accepts requests, WDATA moves the
//                  write data of a just-granted write).
//   client_e     : client identifier, also the payload of the read-ID FIFO.
//   other_client : returns the opposite client, used for round-robin.
// -----------------------------------------------------------------------------
`ifndef MEM_DATA_BITS
`define MEM_DATA_BITS 128
`endif

package mem_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    WDATA = 1'b1
  } arb_state_e;

  typedef enum logic {
    IC = 1'b0,
    DC = 1'b1
  } client_e;

  function automatic client_e other_client(input client_e c);
    return (c == IC) ? DC : IC;
  endfunction

endpackage

// File: rtl/arb_id_fifo.sv
// -----------------------------------------------------------------------------
// arb_id_fifo
// Small FIFO of client IDs, one entry per read accepted by memory and not yet
// answered. Memory answers in order, so the head names the owner of the next
// response.
// Ports:
//   clk, reset   : clock, asynchronous active-low reset (empties the FIFO)
//   push/push_id : enqueue one ID (ignored when full)
//   pop          : dequeue the head (ignored when empty)
//   head_id      : ID at the head
//   full/empty   : occupancy flags, registered-state based (a same-cycle pop
//                  does not clear full)
// -----------------------------------------------------------------------------
module arb_id_fifo
  import mem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  client_e push_id,
  input  logic    pop,
  output client_e head_id,
  output logic    full,
  output logic    empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  client_e          slot_q [DEPTH];
  client_e          slot_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign head_id = slot_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    slot_d   = slot_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      slot_d[wr_ptr_q] = push_id;
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    // Simultaneous push and pop leaves the occupancy unchanged.
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Slot contents are only meaningful below count_q, so they need no reset.
  always_ff @(posedge clk) begin
    slot_q <= slot_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Arbitrates the I-cache (ic) and D-cache (dc) memory request channels onto a
// single memory port and routes in-order read responses back to their owner.
// Ports:
//   clk, reset                 : clock, asynchronous active-low reset
//   {ic,dc}_mem_req_*          : client request channel (valid/ready, addr, rw)
//   {ic,dc}_mem_req_data_*     : client write-data channel (valid/ready, bits,
//                                byte mask)
//   {ic,dc}_mem_resp_*         : read response (valid per client, data shared)
//   mem_req_*, mem_req_data_*  : memory request / write-data channels
//   mem_resp_valid/data        : memory read responses, in order, no stall
// Grant is combinational (no added latency). A granted write locks the data
// channel to its client until one data beat is transferred; requests are not
// accepted meanwhile.
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_BITS   = 28,
  parameter int unsigned DATA_BITS   = `MEM_DATA_BITS,
  parameter int unsigned OUTSTANDING = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  // I-cache client
  input  logic                   ic_mem_req_valid,
  output logic                   ic_mem_req_ready,
  input  logic [ADDR_BITS-1:0]   ic_mem_req_addr,
  input  logic                   ic_mem_req_rw,
  input  logic                   ic_mem_req_data_valid,
  output logic                   ic_mem_req_data_ready,
  input  logic [DATA_BITS-1:0]   ic_mem_req_data_bits,
  input  logic [DATA_BITS/8-1:0] ic_mem_req_data_mask,
  output logic                   ic_mem_resp_valid,
  output logic [DATA_BITS-1:0]   ic_mem_resp_data,
  // D-cache client
  input  logic                   dc_mem_req_valid,
  output logic                   dc_mem_req_ready,
  input  logic [ADDR_BITS-1:0]   dc_mem_req_addr,
  input  logic                   dc_mem_req_rw,
  input  logic                   dc_mem_req_data_valid,
  output logic                   dc_mem_req_data_ready,
  input  logic [DATA_BITS-1:0]   dc_mem_req_data_bits,
  input  logic [DATA_BITS/8-1:0] dc_mem_req_data_mask,
  output logic                   dc_mem_resp_valid,
  output logic [DATA_BITS-1:0]   dc_mem_resp_data,
  // Memory side
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic [ADDR_BITS-1:0]   mem_req_addr,
  output logic                   mem_req_rw,
  output logic                   mem_req_data_valid,
  input  logic                   mem_req_data_ready,
  output logic [DATA_BITS-1:0]   mem_req_data_bits,
  output logic [DATA_BITS/8-1:0] mem_req_data_mask,
  input  logic                   mem_resp_valid,
  input  logic [DATA_BITS-1:0]   mem_resp_data
);

  arb_state_e state_q, state_d;
  client_e    last_grant_q, last_grant_d;
  client_e    lock_id_q, lock_id_d;

  client_e    winner;
  client_e    fifo_head;
  logic       fifo_full, fifo_empty;
  logic       ic_elig, dc_elig, any_elig;
  logic       rd_push, resp_pop;

  // Ungated handshake signals; the ports below are forced low during reset.
  logic       req_valid_int;
  logic       ic_req_ready_int, dc_req_ready_int;
  logic       wdata_valid_int;
  logic       ic_dready_int, dc_dready_int;

  // ---------------------------------------------------------------------------
  // Eligibility and round-robin winner selection
  // ---------------------------------------------------------------------------
  // A read may only be presented when its ID has room in the FIFO. The check
  // uses registered occupancy, so a response popping this cycle does not help.
  always_comb begin
    ic_elig  = ic_mem_req_valid && (ic_mem_req_rw || !fifo_full);
    dc_elig  = dc_mem_req_valid && (dc_mem_req_rw || !fifo_full);
    any_elig = ic_elig || dc_elig;
    if (ic_elig && dc_elig) begin
      winner = other_client(last_grant_q);
    end else if (dc_elig) begin
      winner = DC;
    end else begin
      winner = IC;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and channel muxing
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d          = state_q;
    last_grant_d     = last_grant_q;
    lock_id_d        = lock_id_q;
    req_valid_int    = 1'b0;
    ic_req_ready_int = 1'b0;
    dc_req_ready_int = 1'b0;
    wdata_valid_int  = 1'b0;
    ic_dready_int    = 1'b0;
    dc_dready_int    = 1'b0;
    rd_push          = 1'b0;

    mem_req_addr      = (winner == DC) ? dc_mem_req_addr : ic_mem_req_addr;
    mem_req_rw        = (winner == DC) ? dc_mem_req_rw   : ic_mem_req_rw;
    mem_req_data_bits = (lock_id_q == DC) ? dc_mem_req_data_bits
                                          : ic_mem_req_data_bits;
    mem_req_data_mask = (lock_id_q == DC) ? dc_mem_req_data_mask
                                          : ic_mem_req_data_mask;

    case (state_q)
      IDLE: begin
        req_valid_int    = any_elig;
        ic_req_ready_int = any_elig && (winner == IC) && mem_req_ready;
        dc_req_ready_int = any_elig && (winner == DC) && mem_req_ready;
        if (any_elig && mem_req_ready) begin
          last_grant_d = winner;
          if (mem_req_rw) begin
            state_d   = WDATA;
            lock_id_d = winner;
          end else begin
            rd_push = 1'b1;
          end
        end
      end
      WDATA: begin
        wdata_valid_int = (lock_id_q == DC) ? dc_mem_req_data_valid
                                            : ic_mem_req_data_valid;
        ic_dready_int   = (lock_id_q == IC) && mem_req_data_ready;
        dc_dready_int   = (lock_id_q == DC) && mem_req_data_ready;
        if (wdata_valid_int && mem_req_data_ready) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Response routing: owner comes from the FIFO head; stray responses with
  // nothing outstanding are dropped.
  // ---------------------------------------------------------------------------
  assign resp_pop = mem_resp_valid && !fifo_empty;

  assign ic_mem_resp_data = mem_resp_data;
  assign dc_mem_resp_data = mem_resp_data;

  // Every valid/ready output is held low while reset is asserted.
  assign mem_req_valid         = reset && req_valid_int;
  assign ic_mem_req_ready      = reset && ic_req_ready_int;
  assign dc_mem_req_ready      = reset && dc_req_ready_int;
  assign mem_req_data_valid    = reset && wdata_valid_int;
  assign ic_mem_req_data_ready = reset && ic_dready_int;
  assign dc_mem_req_data_ready = reset && dc_dready_int;
  assign ic_mem_resp_valid     = reset && resp_pop && (fifo_head == IC);
  assign dc_mem_resp_valid     = reset && resp_pop && (fifo_head == DC);

  arb_id_fifo #(
    .DEPTH (OUTSTANDING)
  ) u_id_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (rd_push),
    .push_id (winner),
    .pop     (resp_pop),
    .head_id (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // ---------------------------------------------------------------------------
  // State registers; last_grant resets to IC so DC wins the first tie.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= IC;
      lock_id_q    <= IC;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      lock_id_q    <= lock_id_d;
    end
  end

endmodule
